sorting_network_seq: RTL and testbench



---
 rtl/sorting_network_seq_if.sv | 25 ++
 rtl/sorting_network_seq.sv | 114 +++++++++++
 tb/tb_sorting_network_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sorting_network_seq_if.sv
// Key stream bundle for sorting_network_seq: load side, unload side, status.
interface sorting_network_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, busy
  );
endinterface

// File: rtl/sorting_network_seq.sv
// Frame sorter: load DEPTH keys, DEPTH odd-even transposition passes, unload.
// Define SORTNET_DESCENDING_EN for descending order (same timing).
module sorting_network_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  sorting_network_seq_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_pass;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [WIDTH-1:0] w_pass [DEPTH];
  logic [IW-1:0]    w_idx;
  logic             w_cnt_end;
  logic             w_pass_end;
  logic             w_load;
  logic             w_sort;
  logic             w_out;

  function automatic logic f_swap(
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
`ifdef SORTNET_DESCENDING_EN
    return lo < hi;
`else
    return lo > hi;
`endif
  endfunction

  assign w_idx      = r_cnt[IW-1:0];
  assign w_cnt_end  = (r_cnt == CW'(DEPTH - 1));
  assign w_pass_end = (r_pass == CW'(DEPTH - 1));
  assign w_load     = (r_state == S_LOAD);
  assign w_sort     = (r_state == S_SORT);
  assign w_out      = (r_state == S_OUT);

  // Pairs of one parity are disjoint, so each slot is written at most once.
  always_comb begin
    w_pass = r_buf;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((i[0] == r_pass[0]) &&
          f_swap(r_buf[i], r_buf[i+1])) begin
        w_pass[i]   = r_buf[i+1];
        w_pass[i+1] = r_buf[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_pass  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            if (w_cnt_end) begin
              r_cnt   <= '0;
              r_pass  <= '0;
              r_state <= S_SORT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_SORT: begin
          r_pass <= r_pass + 1'b1;
          if (w_pass_end) begin
            r_cnt   <= '0;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (w_cnt_end) begin
              r_cnt   <= '0;
              r_state <= S_LOAD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Key storage carries no reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (!rst && w_load && bus.in_valid) begin
      r_buf[w_idx] <= bus.in_data;
    end else if (!rst && w_sort) begin
      r_buf <= w_pass;
    end
  end

  assign bus.in_ready  = w_load;
  assign bus.out_valid = w_out;
  assign bus.out_data  = w_out ? r_buf[w_idx] : '0;
  assign bus.out_last  = w_out && w_cnt_end;
  assign bus.busy      = w_sort || w_out;
endmodule

// File: tb/tb_sorting_network_seq.sv
// Scoreboard bench for sorting_network_seq (DEPTH=8, WIDTH=16).
// Expected frames are pushed at stimulus time; a monitor pops on output beats.
module tb_sorting_network_seq;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sorting_network_seq_if #(.WIDTH(WIDTH)) bus ();

  sorting_network_seq #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [WIDTH-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int mon_beat = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain insertion sort of the frame, then queue all beats.
  task automatic push_expected(input logic [WIDTH-1:0] k [DEPTH]);
    logic [WIDTH-1:0] a [DEPTH];
    logic [WIDTH-1:0] t;
    int j;
    a = k;
    for (int i = 1; i < DEPTH; i++) begin
      t = a[i];
      j = i - 1;
`ifdef SORTNET_DESCENDING_EN
      while (j >= 0 && a[j] < t) begin
`else
      while (j >= 0 && a[j] > t) begin
`endif
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(a[i]);
  endtask

  // out_ready driver: 0 = always 1, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: stall stability, beat ordering, out_last, in_ready turnaround.
  initial begin
    logic pv, pr, pl, after_last;
    logic [WIDTH-1:0] pd, e;
    pv = 0; pr = 0; pl = 0; pd = '0; after_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        after_last = 0;
      end else begin
        if (after_last) begin
          check("in_ready_after_last", 32'(bus.in_ready), 32'd1);
          check("out_valid_after_last", 32'(bus.out_valid), 32'd0);
          after_last = 0;
        end
        if (bus.out_valid) begin
          check("in_ready_during_out", 32'(bus.in_ready), 32'd0);
          if (pv && !pr) begin
            check("stall_data", 32'(bus.out_data), 32'(pd));
            check("stall_last", 32'(bus.out_last), 32'(pl));
          end
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_beat", 32'(bus.out_data), 32'hDEAD);
            end else begin
              e = exp_q.pop_front();
              check("out_data", 32'(bus.out_data), 32'(e));
              check("out_last", 32'(bus.out_last),
                    32'(mon_beat == DEPTH - 1));
              if (mon_beat == DEPTH - 1) begin
                mon_beat = 0;
                after_last = 1;
              end else begin
                mon_beat++;
              end
            end
          end
        end
        pv = bus.out_valid;
        pr = bus.out_ready;
        pd = bus.out_data;
        pl = bus.out_last;
      end
    end
  end

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [WIDTH-1:0] k, input int gap);
    logic r;
    int c;
    repeat (gap) idle_cycle();
    bus.in_valid = 1'b1;
    bus.in_data  = k;
    r = 0;
    for (c = 0; c < 100 && !r; c++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!r) check("send_timeout", 32'(c), 32'd0);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_only(input logic [WIDTH-1:0] k [DEPTH],
                           input int gapmax);
    for (int i = 0; i < DEPTH; i++)
      send_key(k[i], gapmax > 0 ? $urandom_range(0, gapmax) : 0);
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] k [DEPTH],
                           input int gapmax,
                           input bit junk);
    int t;
    int c;
    bit done;
    push_expected(k);
    load_only(k, gapmax);
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hAAAA;
    end
    t = 0;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0) check("busy_in_sort", 32'(bus.busy), 32'd1);
      if (bus.out_valid) break;
      t++;
    end
    bus.in_valid = 1'b0;
    check("first_out_latency", 32'(t), 32'(DEPTH));
    done = 0;
    for (c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && bus.in_ready;
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_beat = 0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] fr [DEPTH];
    bit ok;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    fr = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd12, 16'd0, 16'd7, 16'd5};
    run_frame(fr, 0, 0);
    fr = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    run_frame(fr, 0, 0);
    fr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    run_frame(fr, 0, 0);
    for (int i = 0; i < DEPTH; i++) fr[i] = 16'hFFFF;
    run_frame(fr, 0, 0);

    ready_mode = 1;
    for (int i = 0; i < DEPTH; i++) fr[i] = 16'($urandom);
    run_frame(fr, 0, 0);

    ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) fr[i] = 16'($urandom_range(0, 40));
    run_frame(fr, 3, 1);

    // Reset during SORT pass 2 discards the frame.
    fr = '{16'd5, 16'd6, 16'd1, 16'd2, 16'd3, 16'd9, 16'd8, 16'd7};
    load_only(fr, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    apply_reset();

    // Reset while output beat 1 is presented.
    fr = '{16'd30, 16'd10, 16'd20, 16'd0, 16'd5, 16'd15, 16'd25, 16'd35};
    push_expected(fr);
    load_only(fr, 0);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = (mon_beat == 1);
    end
    check("beat1_reached", 32'(ok), 32'd1);
    apply_reset();

    fr = '{16'd4, 16'd2, 16'd4, 16'd1, 16'd9, 16'd0, 16'd3, 16'd4};
    run_frame(fr, 0, 0);

    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < DEPTH; i++) fr[i] = 16'($urandom);
      if (f == 3) fr[2] = fr[5];
      run_frame(fr, 2, f[0]);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
